seq_detect_ctrl: RTL
====================

Name: seq_detect_ctrl

Overview:
- Controller that sequences the four-in-a-row ones/zeros detector from the free-running board clock, replacing direct KEY clocking.
- Synchronises the step key and the serial data switch, and turns each key press into a one-cycle sample strobe.
- Tracks the current run with an FSM and a run counter (no shift register).
- Drives the one-run/zero-run flags and a saturating match counter for LED display.

Parameters:
- RUN_LEN, 4, consecutive equal samples needed to assert a flag; legal range >= 2
- CNT_W, 8, width of match_count
- RL_W, $clog2(RUN_LEN+1), width of run_len (derived; do not override)

Ports:
- clock  in  1  system clock; single clock domain
- resetn  in  1  asynchronous, active-low reset
- w_in  in  1  serial data bit from a switch; asynchronous to clock
- step_n  in  1  step key, active-low, asynchronous; each press = one sample
- clear  in  1  synchronous clear, active-high, already in the clock domain
- z_one  out  1  high while the last RUN_LEN samples were all 1
- z_zero  out  1  high while the last RUN_LEN samples were all 0
- run_len  out  RL_W  length of the current run, saturating at RUN_LEN; 0 in IDLE
- match_count  out  CNT_W  number of samples taken while a flag was, or became, asserted; saturating

Behaviour:
- Reset (resetn low, asynchronous): all sync flops = 1 for step, 0 for w. State = IDLE; run_len = 0; z_one = z_zero = 0; match_count = 0.
- Synchronisation: step_n and w_in each pass through 2 flops (s1, s2), plus a step_prev flop on the step path.
- Sample strobe: smp = step_prev & ~step_s2, i.e. a falling edge, one cycle wide per press. The sampled bit b = w_s2 in the same cycle.
- Latency: step_n first sampled low at edge k → smp high during the cycle after edge k+1 → state and outputs update at edge k+2. The same applies to w_in, so w must be stable for at least 2 cycles before the press.
- FSM states (encoding in package): IDLE, RUN1, RUN0.
  - IDLE + smp: b=1 → RUN1 with run_len=1; b=0 → RUN0 with run_len=1.
  - RUN1 + smp, b=1: stay; run_len = min(run_len+1, RUN_LEN).
  - RUN1 + smp, b=0: → RUN0, run_len=1.
  - RUN0 is symmetric to RUN1.
  - No smp: hold all state.
- Flags: z_one = (state==RUN1) && (run_len==RUN_LEN); z_zero = (state==RUN0) && (run_len==RUN_LEN). Decoded from registers only (no input-to-output path). z_one and z_zero are never both 1.
- run_len saturates at RUN_LEN; a long run keeps its flag high with no wrap.
- match_count: +1 on every smp whose next-state flag is 1. Saturates at 2^CNT_W-1; no wrap.
- clear: at the next edge, state = IDLE, run_len = 0, match_count = 0.
  - clear wins over a simultaneous smp; that sample is discarded.
  - Sync flops are not cleared, so a press in flight is not re-generated.
- Key held low: exactly one smp. Release generates nothing.
- Bounce is out of scope; each clean falling edge is one sample.
- Reset mid-run: flags drop immediately (asynchronously), with no glitch back after release.

Decomposition:
- Shared package: state encoding constants ST_IDLE=2'd0, ST_RUN1=2'd1, ST_RUN0=2'd2, and the RUN_LEN default.
- One sub-module, key_step_sync: 2-flop synchroniser plus falling-edge detect. Ports clock, resetn, async_n, pulse. Reused later for other KEY inputs.
- The w_in synchroniser is inline, with 2 flops matching the step path depth.

Test Plan:
- Reset then idle: resetn low 3 cycles, release, no presses → z_one=0, z_zero=0, run_len=0, match_count=0 for 20 cycles.
- Ones run: w=1, 4 presses 10 cycles apart → run_len 1,2,3,4. z_one rises exactly 3 edges after the 4th press; match_count=1. A 5th press with w=1 → z_one stays 1, run_len=4, match_count=2.
- Run break: after the ones run, press with w=0 → z_one=0, state RUN0, run_len=1. 3 more presses with w=0 → z_zero=1, match_count incremented.
- Alternating 1,0,1,0,… for 10 presses → both flags stay 0, run_len=1 after each press, match_count unchanged.
- Clear collision: clear asserted in the same cycle as smp during a full run → next cycle IDLE, run_len=0, match_count=0, flags 0. The press is not counted.
- Saturation and held key: CNT_W=3, 12 presses with w=1 → match_count stops at 7. Holding step_n low 50 cycles → only one increment. resetn asserted mid-run → all outputs 0 immediately.

Source files
------------

// File: rtl/seq_detect_ctrl_pkg.sv
// Shared types and defaults for the run detector controller.
package seq_detect_ctrl_pkg;

    localparam int unsigned RUN_LEN_DEF = 4;
    localparam int unsigned CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN1 = 2'd1,
        ST_RUN0 = 2'd2
    } state_t;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Board-side signals of the run detector: switch/key inputs and LED outputs.
interface seq_detect_ctrl_if
    import seq_detect_ctrl_pkg::*;
#(
    parameter int unsigned RUN_LEN = RUN_LEN_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
);

    localparam int unsigned RL_W = $clog2(RUN_LEN + 1);

    logic             w_in;
    logic             step_n;
    logic             clear;
    logic             z_one;
    logic             z_zero;
    logic [RL_W-1:0]  run_len;
    logic [CNT_W-1:0] match_count;

    modport master (
        output w_in, step_n, clear,
        input  z_one, z_zero, run_len, match_count
    );

    modport slave (
        input  w_in, step_n, clear,
        output z_one, z_zero, run_len, match_count
    );

endinterface

// File: rtl/seq_detect_ctrl_key_step_sync.sv
// Two-flop synchroniser for an active-low key with a one-cycle falling-edge pulse.
module key_step_sync (
    input  logic clock,
    input  logic resetn,
    input  logic async_n,
    output logic pulse
);

    logic s1;
    logic s2;
    logic prev;

    // Synchroniser chain and edge history; idle level of the key is high.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            prev <= 1'b1;
        end else begin
            s1   <= async_n;
            s2   <= s1;
            prev <= s2;
        end
    end

    // One pulse per press; a held key or its release produces nothing further.
    assign pulse = prev & ~s2;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run detector controller: one sample per key press, tracks the current run of equal bits.
module seq_detect_ctrl
    import seq_detect_ctrl_pkg::*;
#(
    parameter int unsigned RUN_LEN = RUN_LEN_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic            clock,
    input  logic            resetn,
    seq_detect_ctrl_if.slave bus
);

    localparam int unsigned RL_W = $clog2(RUN_LEN + 1);
    localparam logic [RL_W-1:0]  LEN_MAX = RL_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             smp;
    logic             w_s1;
    logic             w_s2;

    state_t           state;
    state_t           state_nxt;
    logic [RL_W-1:0]  len_q;
    logic [RL_W-1:0]  len_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             one_q;
    logic             one_nxt;
    logic             zero_q;
    logic             zero_nxt;

    key_step_sync u_step (
        .clock   (clock),
        .resetn  (resetn),
        .async_n (bus.step_n),
        .pulse   (smp)
    );

    // Data switch synchroniser, same depth as the key path so the bit lines up with smp.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            w_s1 <= 1'b0;
            w_s2 <= 1'b0;
        end else begin
            w_s1 <= bus.w_in;
            w_s2 <= w_s1;
        end
    end

    // State, run length, match counter and flag registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            len_q  <= '0;
            cnt_q  <= '0;
            one_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            len_q  <= len_nxt;
            cnt_q  <= cnt_nxt;
            one_q  <= one_nxt;
            zero_q <= zero_nxt;
        end
    end

    // Next-state: clear beats a coincident sample; flags decode the next registered state.
    always_comb begin
        state_nxt = state;
        len_nxt   = len_q;
        cnt_nxt   = cnt_q;
        one_nxt   = 1'b0;
        zero_nxt  = 1'b0;

        if (bus.clear) begin
            state_nxt = ST_IDLE;
            len_nxt   = '0;
        end else if (smp) begin
            case (state)
                ST_RUN1: begin
                    if (w_s2) begin
                        len_nxt = (len_q == LEN_MAX) ? len_q : len_q + RL_W'(1);
                    end else begin
                        state_nxt = ST_RUN0;
                        len_nxt   = RL_W'(1);
                    end
                end
                ST_RUN0: begin
                    if (!w_s2) begin
                        len_nxt = (len_q == LEN_MAX) ? len_q : len_q + RL_W'(1);
                    end else begin
                        state_nxt = ST_RUN1;
                        len_nxt   = RL_W'(1);
                    end
                end
                default: begin
                    state_nxt = w_s2 ? ST_RUN1 : ST_RUN0;
                    len_nxt   = RL_W'(1);
                end
            endcase
        end

        one_nxt  = (state_nxt == ST_RUN1) && (len_nxt == LEN_MAX);
        zero_nxt = (state_nxt == ST_RUN0) && (len_nxt == LEN_MAX);

        if (bus.clear) begin
            cnt_nxt = '0;
        end else if (smp && (one_nxt || zero_nxt) && (cnt_q != CNT_MAX)) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end
    end

    assign bus.z_one       = one_q;
    assign bus.z_zero      = zero_q;
    assign bus.run_len     = len_q;
    assign bus.match_count = cnt_q;

endmodule
